// File: rtl/sha_round_sequencer.sv
// Iterative SHA-256 compression: one sha_round per cycle over a 16-word schedule window,
// chaining value added back at the end. Optional abort input under `SHA_ABORT_EN.
module sha_round_sequencer #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] chain_i,
  input  logic [511:0] block_i,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_o
`ifdef SHA_ABORT_EN
  ,
  input  logic         abort_i
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_T = CNT_W'(ROUNDS - 1);

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t            r_state;
  state_t            w_state_nx;
  logic [CNT_W-1:0]  r_t;
  logic [31:0]       r_chain [8];
  logic [31:0]       r_work  [8];
  logic [31:0]       r_w     [16];
  logic [255:0]      r_digest;
  logic              w_abort;
  logic              w_accept;

`ifdef SHA_ABORT_EN
  assign w_abort = abort_i;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign digest_o = r_digest;

  // Round datapath: r_work[0..7] = a..h, r_w[0] is W_t.
  logic [31:0] w_k, w_bs0, w_bs1, w_ch, w_maj, w_t1, w_t2, w_s0, w_s1, w_w_new;

  assign w_k     = K_ROM[r_t[5:0]];
  assign w_bs1   = rotr(r_work[4], 6) ^ rotr(r_work[4], 11) ^ rotr(r_work[4], 25);
  assign w_bs0   = rotr(r_work[0], 2) ^ rotr(r_work[0], 13) ^ rotr(r_work[0], 22);
  assign w_ch    = (r_work[4] & r_work[5]) ^ (~r_work[4] & r_work[6]);
  assign w_maj   = (r_work[0] & r_work[1]) ^ (r_work[0] & r_work[2]) ^ (r_work[1] & r_work[2]);
  assign w_t1    = r_work[7] + w_bs1 + w_ch + w_k + r_w[0];
  assign w_t2    = w_bs0 + w_maj;
  assign w_s0    = rotr(r_w[1], 7) ^ rotr(r_w[1], 18) ^ (r_w[1] >> 3);
  assign w_s1    = rotr(r_w[14], 17) ^ rotr(r_w[14], 19) ^ (r_w[14] >> 10);
  assign w_w_new = w_s1 + r_w[9] + w_s0 + r_w[0];

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state logic
  // NOTE: the default assignment up front keeps this combinational block from inferring latches.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nx = S_RUN;
      S_RUN: begin
        if (w_abort)          w_state_nx = S_IDLE;
        else if (r_t == LAST_T) w_state_nx = S_FINAL;
      end
      S_FINAL: w_state_nx = w_abort ? S_IDLE : S_DONE;
      S_DONE:  if (out_ready || w_abort) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Datapath
  // NOTE: the schedule window and working registers are reset to zero so a reset mid-block
  // leaves no residue of the discarded message in the design.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t      <= '0;
      r_digest <= '0;
      for (int i = 0; i < 8; i++) begin
        r_chain[i] <= '0;
        r_work[i]  <= '0;
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_t <= '0;
            for (int i = 0; i < 8; i++) begin
              r_chain[i] <= chain_i[255 - 32*i -: 32];
              r_work[i]  <= chain_i[255 - 32*i -: 32];
            end
            for (int i = 0; i < 16; i++) r_w[i] <= block_i[511 - 32*i -: 32];
          end
        end
        S_RUN: begin
          r_t       <= r_t + 1'b1;
          r_work[0] <= w_t1 + w_t2;
          r_work[1] <= r_work[0];
          r_work[2] <= r_work[1];
          r_work[3] <= r_work[2];
          r_work[4] <= r_work[3] + w_t1;
          r_work[5] <= r_work[4];
          r_work[6] <= r_work[5];
          r_work[7] <= r_work[6];
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15]   <= w_w_new;
        end
        S_FINAL: begin
          // An aborted block must never reach the digest register.
          if (!w_abort) begin
            for (int i = 0; i < 8; i++)
              r_digest[255 - 32*i -: 32] <= r_chain[i] + r_work[i];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_sequencer.sv
// Directed bench for sha_round_sequencer: FIPS "abc" and two-block vectors, backpressure,
// mid-block reset, and the optional abort when SHA_ABORT_EN is defined.
module tb_sha_round_sequencer;

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_BLK =
    512'h61626380_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000018;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [511:0] BLK1 =
    512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
  localparam logic [511:0] BLK2 =
    512'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_000001c0;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] chain_i;
  logic [511:0] block_i;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest_o;
  logic         abort_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  sha_round_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .chain_i   (chain_i),
    .block_i   (block_i),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest_o  (digest_o)
`ifdef SHA_ABORT_EN
    ,
    .abort_i   (abort_i)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one block at the current negedge, then waits for out_valid.
  task automatic run_block(input string tag, input logic [255:0] ch, input logic [511:0] blk,
                           output logic [255:0] dig);
    int n;
    chain_i  = ch;
    block_i  = blk;
    in_valid = 1'b1;
    check({tag, "_acc_ready"}, 256'(in_ready), 256'(1));
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
    n = 1;
    check({tag, "_busy"}, 256'(busy), 256'(1));
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 256'(n), 256'(66));
    dig = digest_o;
  endtask

  initial begin
    logic [255:0] d1;
    logic [255:0] d2;
    int           acc1;
    logic         seen_ov;

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort_i = 1'b0;
    chain_i = '0; block_i = '0;
    #1 rst_n = 1'b0;

    // 1. Reset with in_valid asserted
    in_valid = 1'b1; chain_i = H0; block_i = ABC_BLK;
    repeat (3) tick();
    check("rst_in_ready",  256'(in_ready),  256'(1));
    check("rst_busy",      256'(busy),      256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_digest",    digest_o,        256'(0));
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("post_rst_busy", 256'(busy), 256'(0));

    // 2. "abc" single block
    run_block("abc", H0, ABC_BLK, d1);
    check("abc_digest", d1, ABC_DIG);

    // 3. Backpressure in DONE, with a pulsed in_valid that must be ignored
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        in_valid = 1'b1; chain_i = '1; block_i = '1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_digest",    digest_o,        ABC_DIG);
      check("bp_in_ready",  256'(in_ready),  256'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_out_valid", 256'(out_valid), 256'(0));
    check("hs_in_ready",  256'(in_ready),  256'(1));
    tick();
    check("hs_busy", 256'(busy), 256'(0));

    // 4. Back-to-back two-block message, out_ready held high
    out_ready = 1'b1;
    run_block("blk1", H0, BLK1, d1);
    acc1 = acc_cyc;
    in_valid = 1'b1; chain_i = d1; block_i = BLK2;
    check("b2b_done_not_ready", 256'(in_ready), 256'(0));
    tick();
    run_block("blk2", d1, BLK2, d2);
    check("b2b_spacing", 256'(acc_cyc - acc1), 256'(67));
    check("two_block_digest", d2, TWO_DIG);
    tick();

    // 5. Reset at round 30, then a clean "abc"
    chain_i = H0; block_i = ABC_BLK; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (30) tick();
    check("mid_busy_before", 256'(busy), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready",  256'(in_ready),  256'(1));
    check("mid_rst_busy",      256'(busy),      256'(0));
    check("mid_rst_out_valid", 256'(out_valid), 256'(0));
    check("mid_rst_digest",    digest_o,        256'(0));
    tick();
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      seen_ov = seen_ov | out_valid;
    end
    check("mid_no_out_valid", 256'(seen_ov), 256'(0));
    run_block("abc_after_rst", H0, ABC_BLK, d1);
    check("abc_after_rst_digest", d1, ABC_DIG);
    tick();

`ifdef SHA_ABORT_EN
    // 6. Abort at round 10
    chain_i = H0; block_i = ABC_BLK; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_in_ready",  256'(in_ready),  256'(1));
    check("abort_out_valid", 256'(out_valid), 256'(0));
    seen_ov = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      seen_ov = seen_ov | out_valid;
    end
    check("abort_no_out_valid", 256'(seen_ov), 256'(0));
    run_block("abc_after_abort", H0, ABC_BLK, d1);
    check("abc_after_abort_digest", d1, ABC_DIG);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
